// File: rtl/nrisc_mc_control.sv
// rtl/nrisc_mc_control.sv - multicycle control FSM for the nRISC 8-bit datapath
// Sequences FETCH/DECODE/EXEC/MEM/WB and traps a stalled memory into HALT.
module nrisc_mc_control #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_branch,
  output logic [1:0] alu_op,
  output logic       alu_src_b,
  output logic       reg_write,
  output logic [1:0] sel_reg,
  output logic [2:0] estado,
  output logic       halted,
  output logic       erro
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LI   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             erro_q, erro_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      erro_q  <= erro_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    erro_d    = erro_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_branch = 1'b0;
    alu_op    = 2'b00;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    sel_reg   = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HALT;
          erro_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_HALT: state_d = S_HALT;
          OP_LI:   state_d = S_WB;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            alu_op  = opcode[1:0];
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_op = 2'b01;
            if (zero) begin
              pc_write  = 1'b1;
              pc_branch = 1'b1;
            end
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        // Only LW and SW reach MEM, so a non-store is treated as a load.
        if (opcode == OP_SW) mem_write = 1'b1;
        else                 mem_read  = 1'b1;
        if (mem_ready) begin
          state_d = (opcode == OP_SW) ? S_FETCH : S_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HALT;
          erro_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        case (opcode)
          OP_LW: sel_reg = 2'b01;
          OP_LI: begin
            sel_reg   = 2'b10;
            alu_src_b = 1'b1;
          end
          default: sel_reg = 2'b00;
        endcase
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign estado = state_q;
  assign halted = (state_q == S_HALT);
  assign erro   = erro_q;

endmodule

// File: tb/tb_nrisc_mc_control.sv
// tb/tb_nrisc_mc_control.sv - scoreboard bench for nrisc_mc_control
// Stimulus queues per-cycle expected output vectors; a negedge monitor compares them.
module tb_nrisc_mc_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, ir_write, pc_write, pc_branch;
  logic [1:0] alu_op, sel_reg;
  logic       alu_src_b, reg_write, halted, erro;
  logic [2:0] estado;

  nrisc_mc_control #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_branch(pc_branch), .alu_op(alu_op), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .sel_reg(sel_reg), .estado(estado), .halted(halted), .erro(erro)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // {estado, halted, erro, mem_read, mem_write, ir_write, pc_write, pc_branch, alu_op, alu_src_b, reg_write, sel_reg}
  function automatic logic [15:0] mk(input logic [2:0] st, input logic hl, input logic er,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic pcw, input logic pcb, input logic [1:0] aop,
                                     input logic asb, input logic rw, input logic [1:0] sel);
    return {st, hl, er, mr, mw, irw, pcw, pcb, aop, asb, rw, sel};
  endfunction

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = q.pop_front();
      act = {estado, halted, erro, mem_read, mem_write, ir_write, pc_write, pc_branch,
             alu_op, alu_src_b, reg_write, sel_reg};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got %b required %b", e.nm, act, e.v);
      end
    end
  end

  task automatic cyc(input logic [2:0] op, input logic z, input logic rdy, input logic rst,
                     input logic chk, input logic [15:0] ev, input string nm);
    @(posedge clock);
    #1;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    reset     = rst;
    if (chk) q.push_back('{ev, nm});
  endtask

  initial begin
    logic [15:0] f_hit, f_wait, dec, hlt, hlt_ok;
    f_hit  = mk(3'd0, 0, 0, 1, 0, 1, 1, 0, 2'b00, 0, 0, 2'b00);
    f_wait = mk(3'd0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    dec    = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    hlt    = mk(3'd5, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    hlt_ok = mk(3'd5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);

    cyc(3'b000, 0, 0, 1, 0, '0, "rst");
    cyc(3'b000, 0, 0, 1, 0, '0, "rst");
    cyc(3'b000, 0, 0, 0, 1, f_wait, "reset_state");

    // ADD, SUB, AND with memory always ready
    cyc(3'b000, 0, 1, 0, 1, f_hit, "add_fetch");
    cyc(3'b000, 0, 1, 0, 1, dec, "add_decode");
    cyc(3'b000, 0, 1, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00), "add_exec");
    cyc(3'b000, 0, 1, 0, 1, mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00), "add_wb");
    cyc(3'b001, 0, 1, 0, 1, f_hit, "sub_fetch");
    cyc(3'b001, 0, 1, 0, 1, dec, "sub_decode");
    cyc(3'b001, 0, 1, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00), "sub_exec");
    cyc(3'b001, 0, 1, 0, 1, mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00), "sub_wb");
    cyc(3'b010, 0, 1, 0, 1, f_hit, "and_fetch");
    cyc(3'b010, 0, 1, 0, 1, dec, "and_decode");
    cyc(3'b010, 0, 1, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 2'b00), "and_exec");
    cyc(3'b010, 0, 1, 0, 1, mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00), "and_wb");

    // LW with two wait cycles in MEM
    cyc(3'b011, 0, 1, 0, 1, f_hit, "lw_fetch");
    cyc(3'b011, 0, 1, 0, 1, dec, "lw_decode");
    cyc(3'b011, 0, 1, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 2'b00), "lw_exec");
    for (int i = 0; i < 2; i++)
      cyc(3'b011, 0, 0, 0, 1, mk(3'd3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00), "lw_mem_wait");
    cyc(3'b011, 0, 1, 0, 1, mk(3'd3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00), "lw_mem_done");
    cyc(3'b011, 0, 1, 0, 1, mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b01), "lw_wb");

    // LI then SW
    cyc(3'b101, 0, 1, 0, 1, f_hit, "li_fetch");
    cyc(3'b101, 0, 1, 0, 1, dec, "li_decode");
    cyc(3'b101, 0, 1, 0, 1, mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 2'b10), "li_wb");
    cyc(3'b100, 0, 1, 0, 1, f_hit, "sw_fetch");
    cyc(3'b100, 0, 1, 0, 1, dec, "sw_decode");
    cyc(3'b100, 0, 1, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 2'b00), "sw_exec");
    cyc(3'b100, 0, 1, 0, 1, mk(3'd3, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00), "sw_mem");

    // BEQ taken and not taken
    cyc(3'b110, 1, 1, 0, 1, f_hit, "beq1_fetch");
    cyc(3'b110, 1, 1, 0, 1, dec, "beq1_decode");
    cyc(3'b110, 1, 1, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 1, 1, 2'b01, 0, 0, 2'b00), "beq_taken_exec");
    cyc(3'b110, 0, 1, 0, 1, f_hit, "beq0_fetch");
    cyc(3'b110, 0, 1, 0, 1, dec, "beq0_decode");
    cyc(3'b110, 0, 1, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00), "beq_not_taken_exec");

    // seven FETCH waits then ready on the last allowed cycle: no trap
    for (int i = 0; i < 7; i++) cyc(3'b101, 0, 0, 0, 1, f_wait, "fetch_wait_edge");
    cyc(3'b101, 0, 1, 0, 1, f_hit, "fetch_late_hit");
    cyc(3'b101, 0, 1, 0, 1, dec, "late_li_decode");
    cyc(3'b101, 0, 1, 0, 1, mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 2'b10), "late_li_wb");

    // memory stuck low in FETCH traps after eight cycles
    for (int i = 0; i < 8; i++) cyc(3'b000, 0, 0, 0, 1, f_wait, "stuck_fetch");
    for (int i = 0; i < 4; i++) cyc(3'b000, 0, i[0], 0, 1, hlt, "timeout_halt");
    cyc(3'b000, 0, 0, 1, 0, '0, "rst");
    cyc(3'b000, 0, 0, 0, 1, f_wait, "post_reset_clear");

    // HALT opcode holds while mem_ready toggles
    cyc(3'b111, 0, 1, 0, 1, f_hit, "halt_fetch");
    cyc(3'b111, 0, 1, 0, 1, dec, "halt_decode");
    for (int i = 0; i < 20; i++) cyc(3'(i), 0, i[0], 0, 1, hlt_ok, "halt_hold");
    cyc(3'b000, 0, 0, 1, 0, '0, "rst");

    // reset during EXEC aborts the instruction before WB
    cyc(3'b000, 0, 1, 0, 1, f_hit, "abort_fetch");
    cyc(3'b000, 0, 1, 0, 1, dec, "abort_decode");
    cyc(3'b000, 0, 1, 1, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00), "abort_exec");
    cyc(3'b000, 0, 0, 0, 1, f_wait, "abort_refetch");
    cyc(3'b000, 0, 0, 0, 1, f_wait, "abort_refetch2");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
